// File: rtl/param_bus_proc_pkg.sv
// Shared constants for the parametrised multicycle bus processor:
// opcodes, control-step encoding and bus-source select indices.
package param_bus_proc_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  // One-hot bus select layout: {R(N-1)..R0, G, DIN}
  localparam int unsigned SEL_DIN = 0;
  localparam int unsigned SEL_G   = 1;
  localparam int unsigned SEL_R0  = 2;

endpackage

// File: rtl/param_bus_alu.sv
// Combinational ALU: result = a op b; mv/mvi codes pass b through.
module param_bus_alu
  import param_bus_proc_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = DATA_W'($signed(a) < $signed(b));
      default: result = b;
    endcase
  end

endmodule

// File: rtl/param_bus_processor.sv
// Multicycle bus processor: register file, T0..T3 control FSM and a
// one-hot shared bus carrying DIN, G or one general register per cycle.
module param_bus_processor
  import param_bus_proc_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] DIN,
  output logic              done,
  output logic [DATA_W-1:0] busWires,
  output logic              zero
);

  localparam int unsigned REG_BITS = $clog2(NUM_REGS);
  localparam int unsigned IR_W     = OP_W + 2 * REG_BITS;
  localparam int unsigned SEL_W    = SEL_R0 + NUM_REGS;

  state_t                state, next_state;
  logic [IR_W-1:0]       ir;
  logic [DATA_W-1:0]     a, g, bus_val, alu_result;
  logic [DATA_W-1:0]     r [NUM_REGS];
  logic [SEL_W-1:0]      sel;
  logic [NUM_REGS-1:0]   reg_sel, x_hot, y_hot;
  logic                  ir_load, a_load, g_load, rx_write;
  logic [OP_W-1:0]       ir_op;
  logic [REG_BITS-1:0]   ir_x, ir_y;

  assign ir_op   = ir[IR_W-1 -: OP_W];
  assign ir_x    = ir[2*REG_BITS-1 -: REG_BITS];
  assign ir_y    = ir[REG_BITS-1:0];
  assign x_hot   = NUM_REGS'(1) << ir_x;
  assign y_hot   = NUM_REGS'(1) << ir_y;
  assign reg_sel = sel[SEL_R0 +: NUM_REGS];

  param_bus_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (ir_op),
    .a      (a),
    .b      (bus_val),
    .result (alu_result)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= T0;
      ir    <= '0;
      a     <= '0;
      g     <= '0;
      zero  <= 1'b0;
      r     <= '{default: '0};
    end else begin
      state <= next_state;
      if (ir_load) ir <= DIN[IR_W-1:0];
      if (a_load)  a  <= bus_val;
      if (g_load) begin
        g    <= alu_result;
        zero <= (alu_result == '0);
      end
      if (rx_write) r[ir_x] <= bus_val;
    end
  end

  // Control steps: decode state+IR into bus select and load strobes
  always_comb begin
    next_state = state;
    done       = 1'b0;
    sel        = '0;
    ir_load    = 1'b0;
    a_load     = 1'b0;
    g_load     = 1'b0;
    rx_write   = 1'b0;
    case (state)
      T0: begin
        if (run) begin
          ir_load    = 1'b1;
          next_state = T1;
        end
      end
      T1: begin
        if (ir_op == OP_MV) begin
          sel[SEL_R0 +: NUM_REGS] = y_hot;
          rx_write   = 1'b1;
          done       = 1'b1;
          next_state = T0;
        end else if (ir_op == OP_MVI) begin
          sel[SEL_DIN] = 1'b1;
          rx_write     = 1'b1;
          done         = 1'b1;
          next_state   = T0;
        end else begin
          sel[SEL_R0 +: NUM_REGS] = x_hot;
          a_load     = 1'b1;
          next_state = T2;
        end
      end
      T2: begin
        sel[SEL_R0 +: NUM_REGS] = y_hot;
        g_load     = 1'b1;
        next_state = T3;
      end
      T3: begin
        sel[SEL_G] = 1'b1;
        rx_write   = 1'b1;
        done       = 1'b1;
        next_state = T0;
      end
      default: next_state = T0;
    endcase
  end

  // Bus mux: OR of selected sources, zero when nothing drives
  always_comb begin
    bus_val = '0;
    if (sel[SEL_DIN]) bus_val = bus_val | DIN;
    if (sel[SEL_G])   bus_val = bus_val | g;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_sel[REG_BITS'(i)]) bus_val = bus_val | r[REG_BITS'(i)];
    end
  end

  assign busWires = bus_val;

endmodule

// File: tb/tb_param_bus_processor.sv
// Directed bench for param_bus_processor: default 16-bit/8-reg instance plus
// a 32-bit/16-reg instance for the parameter sweep.
module tb_param_bus_processor;

  localparam logic [2:0] MV = 3'd0, MVI = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] AND_OP = 3'd4, OR_OP = 3'd5, XOR_OP = 3'd6, SLT = 3'd7;

  logic        clock;
  logic        reset, run, run2;
  logic [15:0] din, bus;
  logic [31:0] din2, bus2;
  logic        done, done2, zero, zero2;

  int total;
  int bad;
  bit hold_run;

  logic [15:0] blog  [4];
  logic        dlog  [4];
  logic [31:0] blog2 [4];
  logic        dlog2 [4];

  param_bus_processor dut (
    .clock(clock), .reset(reset), .run(run), .DIN(din),
    .done(done), .busWires(bus), .zero(zero)
  );

  param_bus_processor #(.DATA_W(32), .NUM_REGS(16)) dut_wide (
    .clock(clock), .reset(reset), .run(run2), .DIN(din2),
    .done(done2), .busWires(bus2), .zero(zero2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Drive one instruction on the narrow DUT, logging bus/done per step
  task automatic exec(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                      input logic [15:0] imm);
    int n = (op == MV || op == MVI) ? 2 : 4;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      run = (c == 0) || hold_run;
      din = (c == 0) ? {7'b0, op, x, y} : imm;
      #1;
      blog[c] = bus;
      dlog[c] = done;
    end
  endtask

  task automatic exec2(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                       input logic [31:0] imm);
    int n = (op == MV || op == MVI) ? 2 : 4;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      run2 = (c == 0) || hold_run;
      din2 = (c == 0) ? {21'b0, op, x, y} : imm;
      #1;
      blog2[c] = bus2;
      dlog2[c] = done2;
    end
  endtask

  task automatic rd(input logic [2:0] k, output logic [15:0] v);
    exec(MV, k, k, 16'h0);
    v = blog[1];
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      run  = 1'b0;
      run2 = 1'b0;
      din  = 16'hA5A5 ^ 16'(c);
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    @(negedge clock);
    run = 1'b1;
    din = 16'b0000000_001_000_000;
    @(negedge clock);
    reset = 1'b0;
    run   = 1'b0;
    #1;
    total++; if (bus !== 16'h0) begin bad++; $display("FAIL reset_bus got=%h exp=%h", bus, 16'h0); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", zero); end
    total++; if (bus2 !== 32'h0) begin bad++; $display("FAIL reset_bus_wide got=%h exp=0", bus2); end
    for (int k = 0; k < 8; k++) begin
      rd(3'(k), v);
      total++; if (v !== 16'h0) begin bad++; $display("FAIL reset_r%0d got=%h exp=0000", k, v); end
    end
  endtask

  task automatic test_mvi();
    logic [15:0] v;
    exec(MVI, 3'd0, 3'd0, 16'h0005);
    total++; if (dlog[0] !== 1'b0) begin bad++; $display("FAIL mvi_t0_done got=%b exp=0", dlog[0]); end
    total++; if (blog[1] !== 16'h0005) begin bad++; $display("FAIL mvi_t1_bus got=%h exp=0005", blog[1]); end
    total++; if (dlog[1] !== 1'b1) begin bad++; $display("FAIL mvi_t1_done got=%b exp=1", dlog[1]); end
    rd(3'd0, v);
    total++; if (v !== 16'h0005) begin bad++; $display("FAIL mvi_r0 got=%h exp=0005", v); end
  endtask

  task automatic test_mv_add();
    logic [15:0] v;
    exec(MV, 3'd1, 3'd0, 16'hFFFF);
    total++; if (blog[1] !== 16'h0005 || dlog[1] !== 1'b1) begin
      bad++; $display("FAIL mv_t1 got=%h/%b exp=0005/1", blog[1], dlog[1]); end
    exec(ADD, 3'd0, 3'd1, 16'h1234);
    total++; if (blog[1] !== 16'h0005) begin bad++; $display("FAIL add_t1_bus got=%h exp=0005", blog[1]); end
    total++; if (blog[2] !== 16'h0005) begin bad++; $display("FAIL add_t2_bus got=%h exp=0005", blog[2]); end
    total++; if (blog[3] !== 16'h000A) begin bad++; $display("FAIL add_t3_bus got=%h exp=000a", blog[3]); end
    total++; if ({dlog[0], dlog[1], dlog[2], dlog[3]} !== 4'b0001) begin
      bad++; $display("FAIL add_done_seq got=%b%b%b%b exp=0001", dlog[0], dlog[1], dlog[2], dlog[3]); end
    #1;
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL add_zero got=%b exp=0", zero); end
    rd(3'd0, v);
    total++; if (v !== 16'h000A) begin bad++; $display("FAIL add_r0 got=%h exp=000a", v); end
  endtask

  task automatic test_wrap_zero();
    logic [15:0] v;
    exec(MVI, 3'd0, 3'd0, 16'hFFFF);
    exec(MVI, 3'd1, 3'd0, 16'h0001);
    exec(ADD, 3'd0, 3'd1, 16'h0);
    total++; if (blog[3] !== 16'h0000) begin bad++; $display("FAIL wrap_sum got=%h exp=0000", blog[3]); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL wrap_zero got=%b exp=1", zero); end
    exec(MVI, 3'd2, 3'd0, 16'h0007);
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL mvi_keeps_zero got=%b exp=1", zero); end
    exec(ADD, 3'd2, 3'd2, 16'h0);
    total++; if (blog[3] !== 16'h000E || zero !== 1'b0) begin
      bad++; $display("FAIL double_r2 got=%h/%b exp=000e/0", blog[3], zero); end
    exec(SUB, 3'd1, 3'd1, 16'h0);
    total++; if (blog[3] !== 16'h0000 || zero !== 1'b1) begin
      bad++; $display("FAIL sub_self got=%h/%b exp=0000/1", blog[3], zero); end
    rd(3'd1, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL sub_r1 got=%h exp=0000", v); end
  endtask

  task automatic test_logic();
    logic [15:0] v;
    exec(MVI, 3'd2, 3'd0, 16'h8000);
    exec(MVI, 3'd3, 3'd0, 16'h0001);
    exec(SLT, 3'd2, 3'd3, 16'h0);
    total++; if (blog[3] !== 16'h0001) begin bad++; $display("FAIL slt_neg got=%h exp=0001", blog[3]); end
    rd(3'd2, v);
    total++; if (v !== 16'h0001) begin bad++; $display("FAIL slt_r2 got=%h exp=0001", v); end
    exec(XOR_OP, 3'd3, 3'd3, 16'h0);
    total++; if (blog[3] !== 16'h0000 || zero !== 1'b1) begin
      bad++; $display("FAIL xor_self got=%h/%b exp=0000/1", blog[3], zero); end
    exec(MVI, 3'd4, 3'd0, 16'h00F0);
    exec(MVI, 3'd5, 3'd0, 16'h0F00);
    exec(OR_OP, 3'd4, 3'd5, 16'h0);
    total++; if (blog[3] !== 16'h0FF0 || zero !== 1'b0) begin
      bad++; $display("FAIL or got=%h/%b exp=0ff0/0", blog[3], zero); end
    exec(AND_OP, 3'd4, 3'd5, 16'h0);
    total++; if (blog[3] !== 16'h0F00) begin bad++; $display("FAIL and got=%h exp=0f00", blog[3]); end
    exec(MVI, 3'd6, 3'd0, 16'h0001);
    exec(MVI, 3'd7, 3'd0, 16'h8000);
    exec(SLT, 3'd6, 3'd7, 16'h0);
    total++; if (blog[3] !== 16'h0000) begin bad++; $display("FAIL slt_pos got=%h exp=0000", blog[3]); end
    exec(MVI, 3'd6, 3'd0, 16'h0003);
    exec(MVI, 3'd7, 3'd0, 16'h0005);
    exec(SUB, 3'd6, 3'd7, 16'h0);
    total++; if (blog[3] !== 16'hFFFE) begin bad++; $display("FAIL sub_neg got=%h exp=fffe", blog[3]); end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      run = 1'b0;
      din = 16'b0000000_001_111_000;
      #1;
      total++; if (bus !== 16'h0 || done !== 1'b0) begin
        bad++; $display("FAIL idle_%0d got=%h/%b exp=0000/0", c, bus, done); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    exec(MVI, 3'd0, 3'd0, 16'h0003);
    exec(MVI, 3'd1, 3'd0, 16'h0004);
    exec(XOR_OP, 3'd5, 3'd5, 16'h0);
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL pre_reset_zero got=%b exp=1", zero); end
    @(negedge clock); run = 1'b1; din = {7'b0, ADD, 3'd0, 3'd1};
    @(negedge clock); run = 1'b0; #1;
    total++; if (bus !== 16'h0003) begin bad++; $display("FAIL mid_t1_bus got=%h exp=0003", bus); end
    @(negedge clock); reset = 1'b1; run = 1'b1; din = {7'b0, MVI, 3'd2, 3'd0}; #1;
    total++; if (bus !== 16'h0004 || done !== 1'b0) begin
      bad++; $display("FAIL mid_t2 got=%h/%b exp=0004/0", bus, done); end
    @(negedge clock); reset = 1'b0; run = 1'b0; #1;
    total++; if (bus !== 16'h0 || done !== 1'b0 || zero !== 1'b0) begin
      bad++; $display("FAIL after_reset got=%h/%b/%b exp=0000/0/0", bus, done, zero); end
    @(negedge clock); #1;
    total++; if (bus !== 16'h0 || done !== 1'b0) begin
      bad++; $display("FAIL run_ignored_in_reset got=%h/%b exp=0000/0", bus, done); end
    rd(3'd0, v);
    total++; if (v !== 16'h0) begin bad++; $display("FAIL mid_r0 got=%h exp=0000", v); end
    rd(3'd1, v);
    total++; if (v !== 16'h0) begin bad++; $display("FAIL mid_r1 got=%h exp=0000", v); end
    rd(3'd5, v);
    total++; if (v !== 16'h0) begin bad++; $display("FAIL mid_r5 got=%h exp=0000", v); end
  endtask

  task automatic test_back_to_back();
    hold_run = 1'b1;
    exec(MVI, 3'd3, 3'd0, 16'h1111);
    exec(MVI, 3'd4, 3'd0, 16'h2222);
    exec(ADD, 3'd3, 3'd4, 16'h0);
    total++; if (blog[3] !== 16'h3333 || {dlog[0], dlog[1], dlog[2], dlog[3]} !== 4'b0001) begin
      bad++; $display("FAIL b2b_add got=%h exp=3333", blog[3]); end
    exec(MV, 3'd6, 3'd3, 16'h0);
    total++; if (blog[1] !== 16'h3333) begin bad++; $display("FAIL b2b_mv got=%h exp=3333", blog[1]); end
    hold_run = 1'b0;
    idle(1);
  endtask

  task automatic test_wide();
    hold_run = 1'b1;
    exec2(MVI, 4'd15, 4'd0, 32'hDEADBEEF);
    total++; if (blog2[1] !== 32'hDEADBEEF || dlog2[1] !== 1'b1) begin
      bad++; $display("FAIL wide_mvi got=%h/%b exp=deadbeef/1", blog2[1], dlog2[1]); end
    exec2(MV, 4'd0, 4'd15, 32'h0);
    total++; if (blog2[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL wide_mv got=%h exp=deadbeef", blog2[1]); end
    exec2(ADD, 4'd0, 4'd15, 32'h0);
    total++; if (blog2[3] !== 32'hBD5B7DDE || {dlog2[0], dlog2[1], dlog2[2], dlog2[3]} !== 4'b0001) begin
      bad++; $display("FAIL wide_add got=%h exp=bd5b7dde", blog2[3]); end
    total++; if (zero2 !== 1'b0) begin bad++; $display("FAIL wide_zero got=%b exp=0", zero2); end
    exec2(MV, 4'd1, 4'd0, 32'h0);
    total++; if (blog2[1] !== 32'hBD5B7DDE) begin bad++; $display("FAIL wide_r0 got=%h exp=bd5b7dde", blog2[1]); end
    hold_run = 1'b0;
    idle(1);
    #1;
    total++; if (bus2 !== 32'h0 || done2 !== 1'b0) begin
      bad++; $display("FAIL wide_idle got=%h/%b exp=0/0", bus2, done2); end
  endtask

  initial begin
    total = 0; bad = 0; hold_run = 1'b0;
    reset = 1'b1; run = 1'b0; run2 = 1'b0; din = '0; din2 = '0;
    test_reset();
    test_mvi();
    test_mv_add();
    test_wrap_zero();
    test_logic();
    test_idle();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
